// File: rtl/rbz_spi_pkg.sv
// Shared definitions for the SPI-fed loaders.
// Holds the vector-set defaults, the frame length, the receive state
// enum and the component index constants used to slice o_vectors.
package rbz_spi_pkg;

    localparam int DEF_VEC_W   = 16;
    localparam int DEF_NUM_VEC = 6;
    localparam int FRAME_BITS  = DEF_VEC_W * DEF_NUM_VEC;

    // Component index within o_vectors; px sits in the top slice.
    localparam int PX = 5;
    localparam int PY = 4;
    localparam int FX = 3;
    localparam int FY = 2;
    localparam int VX = 1;
    localparam int VY = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_vec_loader_if.sv
// SPI pin bundle for the vector loader.
//   sclk : SPI clock (mode 0, sampled on rising edge), asynchronous
//   mosi : SPI data, asynchronous
//   csb  : chip select, active-low, asynchronous
// master drives the pins (host / testbench), slave receives them.
interface spi_vec_if;
    logic sclk;
    logic mosi;
    logic csb;

    modport master (output sclk, output mosi, output csb);
    modport slave  (input  sclk, input  mosi, input  csb);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin.
//   clk, rst_n : destination clock, async active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronised output (2 clk latency)
// RST_VAL sets the idle level both flops load on reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/spi_vec_loader.sv
// Receives a frame of NUM_VEC vector components over SPI into a shadow
// buffer and commits it to the live outputs on i_vblank_start, so the
// tracer never sees a half-written vector set.
//   clk, rst_n     : pixel clock, async active-low reset
//   spi            : SPI pins (sclk/mosi/csb), all asynchronous
//   i_vblank_start : one-cycle pulse at start of vertical blanking
//   o_vectors      : live vectors, px in the top VEC_W bits
//   o_pending      : shadow holds a complete, uncommitted frame
//   o_updated      : one-cycle pulse when o_vectors changes
//   o_frame_err    : one-cycle pulse when a frame is cut short
//   o_busy         : transfer in progress
module spi_vec_loader
    import rbz_spi_pkg::*;
#(
    parameter int VEC_W   = DEF_VEC_W,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter logic [NUM_VEC*VEC_W-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_vec_if.slave                   spi,
    input  logic                       i_vblank_start,
    output logic [NUM_VEC*VEC_W-1:0]   o_vectors,
    output logic                       o_pending,
    output logic                       o_updated,
    output logic                       o_frame_err,
    output logic                       o_busy
);

    localparam int FB    = NUM_VEC * VEC_W;
    localparam int CNT_W = $clog2(FB + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FB - 1);

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_csb_s;
    logic w_rise;
    logic [FB-1:0] w_shift_nxt;

    logic          r_sclk_d;
    spi_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FB-1:0] r_shift;
    logic [FB-1:0] r_shadow;
    logic [FB-1:0] r_live;
    logic          r_pending;
    logic          r_updated;
    logic          r_frame_err;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(spi.sclk), .o_q(w_sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(spi.mosi), .o_q(w_mosi_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst_n(rst_n), .i_d(spi.csb), .o_q(w_csb_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sclk_d <= 1'b0;
        else        r_sclk_d <= w_sclk_s;
    end

    // mosi has the same synchroniser depth as sclk, so the value seen
    // alongside the detected rise is the one the host set up before it.
    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_shift_nxt = {r_shift[FB-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_shadow    <= '0;
            r_live      <= RESET_VEC;
            r_pending   <= 1'b0;
            r_updated   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_updated   <= 1'b0;
            r_frame_err <= 1'b0;

            // Commit uses the registered pending flag, so a frame that
            // completes in this same cycle waits for the next vblank.
            if (i_vblank_start && r_pending) begin
                r_live    <= r_shadow;
                r_pending <= 1'b0;
                r_updated <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_csb_s) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_csb_s) begin
                        // Deselect with no bits is just a stray csb blip.
                        if (r_cnt != '0) r_frame_err <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_rise) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_IDX) begin
                            // Assigned after the commit above so a new
                            // frame leaves pending set (latest wins).
                            r_shadow  <= w_shift_nxt;
                            r_pending <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Surplus sclk edges are dropped until deselect.
                    if (w_csb_s) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_vectors   = r_live;
    assign o_pending   = r_pending;
    assign o_updated   = r_updated;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_vec_loader.sv
// Self-checking bench for spi_vec_loader: table-driven frame/vblank
// rows, hand-written reset and vblank-collision sequences, then random
// frames against a frame-level reference model.
module tb_spi_vec_loader;

    logic        clk;
    logic        rst_n;
    logic        vblank;
    logic [95:0] vec;
    logic        pending;
    logic        updated;
    logic        frame_err;
    logic        busy;

    spi_vec_if spi_bus ();

    spi_vec_loader dut (
        .clk(clk), .rst_n(rst_n), .spi(spi_bus.slave),
        .i_vblank_start(vblank), .o_vectors(vec), .o_pending(pending),
        .o_updated(updated), .o_frame_err(frame_err), .o_busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    // Pulse counters; a stuck-high output counts once per cycle.
    always @(negedge clk) begin
        if (updated)   upd_cnt++;
        if (frame_err) err_cnt++;
    end

    // Reference model state (frame-level, not bit-level).
    logic [95:0] m_live;
    logic [95:0] m_shadow;
    logic        m_pending;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Clock bits in; bit i of the frame is data[95-i]. Bits past 96 are random.
    task automatic spi_bits(input logic [95:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.mosi = (i < 96) ? data[95-i] : 1'($urandom_range(0, 1));
            repeat (4) @(posedge clk);
            #1 spi_bus.sclk = 1'b1;
            repeat (4) @(posedge clk);
            #1 spi_bus.sclk = 1'b0;
        end
    endtask

    task automatic csb_low();
        @(posedge clk); #1 spi_bus.csb = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic csb_high();
        repeat (4) @(posedge clk); #1 spi_bus.csb = 1'b1;
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic spi_frame(input logic [95:0] data, input int nbits);
        csb_low();
        spi_bits(data, nbits);
        csb_high();
    endtask

    task automatic vblank_pulse();
        @(posedge clk); #1 vblank = 1'b1;
        @(posedge clk); #1 vblank = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    // Model of one transaction: a frame of nbits (0 = none), optional vblank.
    task automatic model_step(input logic [95:0] data, input int nbits, input bit vb,
                              output int exp_err, output int exp_upd);
        exp_err = 0;
        exp_upd = 0;
        if (nbits >= 96) begin
            m_shadow  = data;
            m_pending = 1'b1;
        end else if (nbits > 0) begin
            exp_err = 1;
        end
        if (vb && m_pending) begin
            m_live    = m_shadow;
            m_pending = 1'b0;
            exp_upd   = 1;
        end
    endtask

    typedef struct {
        string       name;
        logic [95:0] data;
        int          nbits;
        bit          vb;
        logic [95:0] exp_vec;
        bit          exp_pend;
        int          exp_err;
        int          exp_upd;
    } row_t;

    localparam logic [95:0] F_SPEC = {16'h0A00, 16'h0C80, 16'h0100, 16'h0000, 16'h0000, 16'hFF80};
    localparam logic [95:0] F_A    = 96'h1111_2222_3333_4444_5555_6666;
    localparam logic [95:0] F_B    = 96'hABCD_0123_8000_7FFF_FFFF_0001;
    localparam logic [95:0] F_C    = 96'hC001_C0DE_F00D_BEEF_1234_5678;
    localparam logic [95:0] F_D    = 96'h0F0F_F0F0_A5A5_5A5A_0001_8000;
    localparam logic [95:0] F_SH   = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    row_t rows[8];

    initial begin
        int e0, u0, exp_err, exp_upd, nb, sel;
        bit vb;
        logic [95:0] d;

        rows[0] = '{"full_frame",  F_SPEC, 96,  1'b1, F_SPEC, 1'b0, 0, 1};
        rows[1] = '{"short_frame", F_SH,   50,  1'b0, F_SPEC, 1'b0, 1, 0};
        rows[2] = '{"frame_a",     F_A,    96,  1'b0, F_SPEC, 1'b1, 0, 0};
        rows[3] = '{"frame_b",     F_B,    96,  1'b0, F_SPEC, 1'b1, 0, 0};
        rows[4] = '{"commit_b",    '0,     0,   1'b1, F_B,    1'b0, 0, 1};
        rows[5] = '{"vblank_idle", '0,     0,   1'b1, F_B,    1'b0, 0, 0};
        rows[6] = '{"extra_edges", F_C,    100, 1'b1, F_C,    1'b0, 0, 1};
        rows[7] = '{"one_bit",     F_D,    1,   1'b1, F_C,    1'b0, 1, 0};

        rst_n = 1'b0; vblank = 1'b0;
        spi_bus.sclk = 1'b0; spi_bus.mosi = 1'b0; spi_bus.csb = 1'b1;
        m_live = '0; m_shadow = '0; m_pending = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("reset_vec",  vec,       96'h0);
        check("reset_pend", 96'(pending),   96'h0);
        check("reset_busy", 96'(busy),      96'h0);
        check("reset_upd",  96'(updated),   96'h0);
        check("reset_err",  96'(frame_err), 96'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // csb blip with no clocks: no error.
        e0 = err_cnt;
        spi_frame('0, 0);
        check("empty_csb_err", 96'(err_cnt - e0), 96'h0);

        for (int r = 0; r < 8; r++) begin
            e0 = err_cnt; u0 = upd_cnt;
            if (rows[r].nbits > 0) spi_frame(rows[r].data, rows[r].nbits);
            if (rows[r].vb) vblank_pulse();
            check({rows[r].name, "_vec"},  vec, rows[r].exp_vec);
            check({rows[r].name, "_pend"}, 96'(pending), 96'(rows[r].exp_pend));
            check({rows[r].name, "_err"},  96'(err_cnt - e0), 96'(rows[r].exp_err));
            check({rows[r].name, "_upd"},  96'(upd_cnt - u0), 96'(rows[r].exp_upd));
            check({rows[r].name, "_busy"}, 96'(busy), 96'h0);
        end
        m_live = F_C; m_shadow = F_C; m_pending = 1'b0;

        // Reset mid-frame after 40 bits.
        csb_low();
        spi_bits(F_A, 40);
        check("mid_busy", 96'(busy), 96'h1);
        rst_n = 1'b0;
        #3;
        check("rst_async_vec", vec, 96'h0);
        @(posedge clk); #1 spi_bus.csb = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_mid_vec",  vec, 96'h0);
        check("rst_mid_pend", 96'(pending), 96'h0);
        check("rst_mid_busy", 96'(busy), 96'h0);
        rst_n = 1'b1;
        m_live = '0; m_shadow = '0; m_pending = 1'b0;
        repeat (2) @(posedge clk); #1;
        u0 = upd_cnt;
        spi_frame(F_D, 96);
        check("post_rst_pend", 96'(pending), 96'h1);
        vblank_pulse();
        check("post_rst_vec", vec, F_D);
        check("post_rst_upd", 96'(upd_cnt - u0), 96'h1);
        m_live = F_D;

        // Last bit captured in the same cycle as vblank_start.
        csb_low();
        spi_bits(F_A, 95);
        spi_bus.mosi = F_A[0];
        repeat (4) @(posedge clk);
        #1 spi_bus.sclk = 1'b1;            // captured 3 edges later
        @(posedge clk); @(posedge clk);
        #1 vblank = 1'b1;
        @(posedge clk); #1 vblank = 1'b0;
        check("coll_pend", 96'(pending), 96'h1);
        check("coll_upd",  96'(updated), 96'h0);
        check("coll_vec",  vec, F_D);
        repeat (4) @(posedge clk); #1 spi_bus.sclk = 1'b0;
        csb_high();
        @(posedge clk); #1 vblank = 1'b1;
        @(posedge clk); #1 vblank = 1'b0;
        check("coll_next_upd", 96'(updated), 96'h1);
        check("coll_next_vec", vec, F_A);
        check("coll_next_pend", 96'(pending), 96'h0);
        repeat (3) @(posedge clk); #1;
        m_live = F_A; m_shadow = F_A; m_pending = 1'b0;

        // Random frames against the reference model.
        for (int it = 0; it < 10; it++) begin
            d   = {$urandom, $urandom, $urandom};
            sel = $urandom_range(0, 3);
            nb  = (sel < 2) ? 96 : (sel == 2) ? $urandom_range(97, 100) : $urandom_range(1, 95);
            vb  = 1'($urandom_range(0, 1));
            e0 = err_cnt; u0 = upd_cnt;
            spi_frame(d, nb);
            if (vb) vblank_pulse();
            model_step(d, nb, vb, exp_err, exp_upd);
            check($sformatf("rand%0d_vec", it),  vec, m_live);
            check($sformatf("rand%0d_pend", it), 96'(pending), 96'(m_pending));
            check($sformatf("rand%0d_err", it),  96'(err_cnt - e0), 96'(exp_err));
            check($sformatf("rand%0d_upd", it),  96'(upd_cnt - u0), 96'(exp_upd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
